// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
//   P_NONE/P_ODD/P_EVE : parity selection values for PARITY_TYPE
//   rx_state_t         : receiver frame-tracking states
//   SAMPLE_TICK        : oversample tick (of 16 per bit cell) at which the line is sampled
//   calc_div           : clocks per 16x oversample tick, rounded to nearest
package uart_pkg;

  localparam int P_NONE = 0;
  localparam int P_ODD  = 1;
  localparam int P_EVE  = 2;

  localparam int SAMPLE_TICK = 7;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  function automatic int calc_div(input int clk_freq, input int baud_rate);
    int d;
    d = (clk_freq + 8 * baud_rate) / (16 * baud_rate);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// 16x oversample tick generator for the UART receiver.
//   iClk  : system clock
//   iRst  : synchronous active-high reset
//   iEn   : run enable; while low the divider is held at zero so the first
//           tick after enabling arrives exactly DIV clocks later
//   oTick : registered one-clock pulse every DIV clocks while enabled
module uart_rx_tick #(
  parameter int DIV = 10
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iEn,
  output logic oTick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge iClk) begin
    if (iRst || !iEn) begin
      cnt   <= '0;
      oTick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      oTick <= 1'b1;
    end else begin
      cnt   <= cnt + CW'(1);
      oTick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB first, optional odd/even parity,
// one or two stop bits.
//   iClk        : system clock, all logic on the rising edge
//   iRst        : synchronous active-high reset
//   iRx         : asynchronous serial input, idle high
//   oData_rx    : data word of the last completed frame
//   oValid_rx   : one-clock pulse when a frame completes
//   oParity_err : parity mismatch of the last frame (always 0 without parity)
//   oFrame_err  : a stop bit of the last frame was sampled low
//   oBusy_rx    : high from start detection until the receiver is idle again
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int BIT_LENGHT  = 8,
  parameter int PARITY_TYPE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iRx,
  output logic [BIT_LENGHT-1:0] oData_rx,
  output logic                  oValid_rx,
  output logic                  oParity_err,
  output logic                  oFrame_err,
  output logic                  oBusy_rx
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);

  localparam logic [3:0] SAMPLE_AT = 4'(SAMPLE_TICK - 1);
  localparam logic [3:0] LAST_DATA = 4'(BIT_LENGHT - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  function automatic logic exp_parity(input logic [BIT_LENGHT-1:0] d);
    if (PARITY_TYPE == P_ODD) return ~^d;
    return ^d;
  endfunction

  // rx_p0/rx_p1 form the synchronizer; rx_p2 is the previous synchronized
  // value, used only for falling-edge detection in IDLE.
  logic rx_p0, rx_p1, rx_p2;
  logic rx;

  rx_state_t             state, state_nx;
  logic [3:0]            tick_cnt, tick_cnt_nx;
  logic [3:0]            bit_cnt, bit_cnt_nx;
  logic [BIT_LENGHT-1:0] shreg, shreg_nx;
  logic                  par_err, par_err_nx;
  logic                  frm_err, frm_err_nx;
  logic [BIT_LENGHT-1:0] data_nx;
  logic                  perr_out_nx, ferr_out_nx, valid_nx;

  logic tick, tick_en, sample;

  assign rx      = rx_p1;
  assign tick_en = (state != IDLE);

  uart_rx_tick #(.DIV(DIV)) u_tick (
    .iClk  (iClk),
    .iRst  (iRst),
    .iEn   (tick_en),
    .oTick (tick)
  );

  // tick_cnt wraps naturally mod 16; a sample is taken on the tick that
  // moves it to SAMPLE_TICK, so every sample is 16 ticks after the last.
  assign sample = tick && (tick_cnt == SAMPLE_AT);

  always_comb begin
    state_nx    = state;
    tick_cnt_nx = tick ? tick_cnt + 4'd1 : tick_cnt;
    bit_cnt_nx  = bit_cnt;
    shreg_nx    = shreg;
    par_err_nx  = par_err;
    frm_err_nx  = frm_err;
    data_nx     = oData_rx;
    perr_out_nx = oParity_err;
    ferr_out_nx = oFrame_err;
    valid_nx    = 1'b0;

    unique case (state)
      IDLE: begin
        tick_cnt_nx = '0;
        if (rx_p2 && !rx) begin
          state_nx   = START;
          bit_cnt_nx = '0;
          par_err_nx = 1'b0;
          frm_err_nx = 1'b0;
        end
      end

      START: begin
        if (sample) state_nx = rx ? IDLE : DATA;
      end

      DATA: begin
        if (sample) begin
          shreg_nx = {rx, shreg[BIT_LENGHT-1:1]};
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_nx = '0;
            state_nx   = (PARITY_TYPE != P_NONE) ? PARITY : STOP;
          end else begin
            bit_cnt_nx = bit_cnt + 4'd1;
          end
        end
      end

      PARITY: begin
        if (sample) begin
          par_err_nx = (rx != exp_parity(shreg));
          state_nx   = STOP;
        end
      end

      STOP: begin
        if (sample) begin
          frm_err_nx = frm_err | ~rx;
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_nx  = '0;
            valid_nx    = 1'b1;
            data_nx     = shreg;
            perr_out_nx = par_err;
            ferr_out_nx = frm_err | ~rx;
            // A low line here is a break or a missing stop bit; hold off
            // new starts until the line has been seen high.
            state_nx    = rx ? IDLE : WAIT_HIGH;
          end else begin
            bit_cnt_nx = bit_cnt + 4'd1;
          end
        end
      end

      WAIT_HIGH: begin
        if (rx) state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rx_p0       <= 1'b1;
      rx_p1       <= 1'b1;
      rx_p2       <= 1'b1;
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_err     <= 1'b0;
      frm_err     <= 1'b0;
      oData_rx    <= '0;
      oValid_rx   <= 1'b0;
      oParity_err <= 1'b0;
      oFrame_err  <= 1'b0;
      oBusy_rx    <= 1'b0;
    end else begin
      rx_p0       <= iRx;
      rx_p1       <= rx_p0;
      rx_p2       <= rx_p1;
      state       <= state_nx;
      tick_cnt    <= tick_cnt_nx;
      bit_cnt     <= bit_cnt_nx;
      shreg       <= shreg_nx;
      par_err     <= par_err_nx;
      frm_err     <= frm_err_nx;
      oData_rx    <= data_nx;
      oValid_rx   <= valid_nx;
      oParity_err <= perr_out_nx;
      oFrame_err  <= ferr_out_nx;
      oBusy_rx    <= (state_nx != IDLE);
    end
  end

endmodule
